// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the digit-serial BCD adder.
package bcd_pkg;

    localparam int         DIGIT_W  = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

endpackage

// File: rtl/bcd_serial_add_ctrl_bcd_adder.sv
// Single-digit BCD adder cell: combinational sum with decimal correction.
module BCDAdder
    import bcd_pkg::*;
(
    input  logic [3:0] inA,
    input  logic [3:0] inB,
    input  logic       carryIn,
    output logic [3:0] sum,
    output logic       carryOut,
    output logic       sumVal
);

    logic [4:0] raw;
    logic [4:0] corr;

    // A binary sum above nine is pushed past the next decade by adding six.
    always_comb begin
        raw      = {1'b0, inA} + {1'b0, inB} + {4'b0000, carryIn};
        corr     = raw + {1'b0, BCD_CORR};
        carryOut = (raw > {1'b0, BCD_MAX});
        sum      = carryOut ? corr[3:0] : raw[3:0];
        sumVal   = (inA <= BCD_MAX) && (inB <= BCD_MAX);
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder sequencer: one BCDAdder cell reused LSD first.
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [4*DIGITS-1:0] opA,
    input  logic [4*DIGITS-1:0] opB,
    input  logic                carryIn,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] result,
    output logic                carryOut,
    output logic                valid
);

    localparam int W     = DIGIT_W * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     op_a_q, op_a_d;
    logic [W-1:0]     op_b_q, op_b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             valid_acc_q, valid_acc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [W-1:0]     result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             valid_q, valid_d;

    logic [3:0]       cell_sum;
    logic             cell_cout;
    logic             cell_val;
    logic [W+3:0]     sum_ext;

    BCDAdder u_cell (
        .inA      (op_a_q[3:0]),
        .inB      (op_b_q[3:0]),
        .carryIn  (carry_q),
        .sum      (cell_sum),
        .carryOut (cell_cout),
        .sumVal   (cell_val)
    );

    // Outputs are loaded on the final ADD edge so they appear together with done.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        valid_acc_d = valid_acc_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        valid_d     = valid_q;
        sum_ext     = {cell_sum, sum_q} >> DIGIT_W;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_a_d      = opA;
                    op_b_d      = opB;
                    carry_d     = carryIn;
                    cnt_d       = '0;
                    valid_acc_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ADD;
                end
            end
            ADD: begin
                op_a_d      = op_a_q >> DIGIT_W;
                op_b_d      = op_b_q >> DIGIT_W;
                sum_d       = sum_ext[W-1:0];
                carry_d     = cell_cout;
                valid_acc_d = valid_acc_q & cell_val;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    result_d    = sum_ext[W-1:0];
                    carry_out_d = cell_cout;
                    valid_d     = valid_acc_q & cell_val;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            valid_acc_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            valid_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            valid_acc_q <= valid_acc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            valid_q     <= valid_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign carryOut = carry_out_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed self-checking bench for bcd_serial_add_ctrl with DIGITS=4.
module tb_bcd_serial_add_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] opA;
    logic [15:0] opB;
    logic        carryIn;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carryOut;
    logic        valid;

    int          assertCount;
    int          failCount;
    logic [15:0] lastResult;
    bit          lastKnown;

    bcd_serial_add_ctrl #(.DIGITS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .opA      (opA),
        .opB      (opB),
        .carryIn  (carryIn),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carryOut (carryOut),
        .valid    (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin);
        @(negedge clk);
        opA     = a;
        opB     = b;
        carryIn = cin;
        start   = 1'b1;
    endtask

    // Runs one addition, watching 12 cycles after acceptance; optionally fires a stray start mid-ADD.
    task automatic runOp(input string tag, input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input bit inject, input bit checkRes, input logic [15:0] expRes,
                         input logic expCout, input logic expValid);
        int          busyCnt;
        int          doneCnt;
        int          latency;
        logic [15:0] resAtDone;
        logic        coutAtDone;
        logic        validAtDone;
        busyCnt     = 0;
        doneCnt     = 0;
        latency     = -1;
        resAtDone   = '0;
        coutAtDone  = 1'b0;
        validAtDone = 1'b0;
        applyStimulus(a, b, cin);
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (inject && k == 1) begin
                opA     = 16'h1111;
                opB     = 16'h2222;
                carryIn = 1'b1;
                start   = 1'b1;
            end
            if (inject && k == 2) start = 1'b0;
            if (k == 2 && lastKnown) checkOutput({tag, "_hold"}, 32'(result), 32'(lastResult));
            if (busy) busyCnt++;
            if (done) begin
                doneCnt++;
                if (latency < 0) begin
                    latency     = k;
                    resAtDone   = result;
                    coutAtDone  = carryOut;
                    validAtDone = valid;
                end
            end
        end
        checkOutput({tag, "_latency"}, 32'(latency), 32'd4);
        checkOutput({tag, "_busycnt"}, 32'(busyCnt), 32'd4);
        checkOutput({tag, "_donecnt"}, 32'(doneCnt), 32'd1);
        if (checkRes) begin
            checkOutput({tag, "_result"}, 32'(resAtDone), 32'(expRes));
            checkOutput({tag, "_cout"}, 32'(coutAtDone), 32'(expCout));
        end
        checkOutput({tag, "_valid"}, 32'(validAtDone), 32'(expValid));
        lastResult = expRes;
        lastKnown  = checkRes;
    endtask

    initial begin
        int doneSeen;
        assertCount = 0;
        failCount   = 0;
        lastResult  = '0;
        lastKnown   = 1'b1;
        reset   = 1'b1;
        start   = 1'b0;
        opA     = '0;
        opB     = '0;
        carryIn = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_result", 32'(result), 32'd0);
        checkOutput("rst_cout", 32'(carryOut), 32'd0);
        checkOutput("rst_valid", 32'(valid), 32'd1);
        reset = 1'b0;

        runOp("t1_zero", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
        runOp("t2_basic", 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b1, 16'h6912, 1'b0, 1'b1);
        runOp("t3_ovf", 16'h9999, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
        runOp("t3_cin", 16'h0005, 16'h0006, 1'b1, 1'b0, 1'b1, 16'h0012, 1'b0, 1'b1);
        runOp("t4_bad", 16'h00A1, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        runOp("t4_good", 16'h0007, 16'h0004, 1'b0, 1'b0, 1'b1, 16'h0011, 1'b0, 1'b1);
        runOp("t5_ignore", 16'h0456, 16'h0789, 1'b0, 1'b1, 1'b1, 16'h1245, 1'b0, 1'b1);

        // Abort in the second ADD cycle: everything returns to reset values at once.
        applyStimulus(16'h1234, 16'h5678, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("t6_busy", 32'(busy), 32'd0);
        checkOutput("t6_result", 32'(result), 32'd0);
        checkOutput("t6_cout", 32'(carryOut), 32'd0);
        checkOutput("t6_valid", 32'(valid), 32'd1);
        doneSeen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 2) reset = 1'b0;
            if (done) doneSeen++;
        end
        checkOutput("t6_nodone", 32'(doneSeen), 32'd0);
        checkOutput("t6_idle_busy", 32'(busy), 32'd0);
        lastResult = '0;
        lastKnown  = 1'b1;
        runOp("t6_after", 16'h4321, 16'h1234, 1'b1, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
